// File: rtl/shift_array_stream_ctrl.sv
// Valid/ready stream controller wrapped around a left-shift register array.
// Tracks per-stage validity so only real words leave the tail, and supports a bubble-inserting flush.
module shift_array_stream_ctrl #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BIT_WIDTH-1:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [BIT_WIDTH-1:0]         arr_in,
    output logic                         arr_enable,
    input  logic [BIT_WIDTH-1:0]         arr_out,
    output logic [BIT_WIDTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         flushing
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [DEPTH-1:0] vbits_r;
    logic [OCC_W-1:0] occ_r;

    logic tail_s;
    logic any_valid_s;
    logic run_s;
    logic shift_req_s;
    logic shift_s;
    logic ins_s;
    logic emit_s;

    // Shift handshake: a shift needs a request and a free (or consumed) tail slot
    always_comb begin
        tail_s      = vbits_r[DEPTH-1];
        any_valid_s = |vbits_r;
        run_s       = (state_r == ST_RUN);
        shift_req_s = run_s ? in_valid : any_valid_s;
        // Gated by reset so every output reads low while the array is held in reset
        shift_s     = reset & shift_req_s & (~tail_s | out_ready);
        ins_s       = shift_s & run_s;
        emit_s      = shift_s & tail_s;
    end

    // Next-state logic for the RUN/FLUSH controller
    always_comb begin
        state_nxt_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (flush && any_valid_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (!any_valid_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stage validity mirror: moves in lockstep with the array
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vbits_r <= {DEPTH{1'b0}};
        end else if (shift_s) begin
            vbits_r <= {vbits_r[DEPTH-2:0], ins_s};
        end else begin
            vbits_r <= vbits_r;
        end
    end

    // Occupancy counter: a simultaneous insert and emit leaves it unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_r <= {OCC_W{1'b0}};
        end else if (ins_s && !emit_s) begin
            occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
        end else if (emit_s && !ins_s) begin
            occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
        end else begin
            occ_r <= occ_r;
        end
    end

    // Output drive: flush shifts push zero bubbles into stage 0
    always_comb begin
        arr_enable = shift_s;
        arr_in     = ins_s ? in_data : {BIT_WIDTH{1'b0}};
        out_data   = arr_out;
        out_valid  = reset & tail_s & shift_req_s;
        in_ready   = reset & run_s & (~tail_s | out_ready);
        occupancy  = occ_r;
        flushing   = reset & (state_r == ST_FLUSH);
    end

endmodule

// File: tb/tb_shift_array_stream_ctrl.sv
// Bench for shift_array_stream_ctrl: directed scenarios plus random traffic,
// checked every cycle against a slot-level model of the array contents.
module tb_shift_array_stream_ctrl;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [W-1:0] arr_in;
    logic         arr_enable;
    logic [W-1:0] arr_out;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   occupancy;
    logic         flushing;

    int tests = 0;
    int fails = 0;

    shift_array_stream_ctrl #(.BIT_WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush),
        .arr_in(arr_in), .arr_enable(arr_enable), .arr_out(arr_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .flushing(flushing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shift array itself, sharing the controller's reset
    logic [W-1:0] arr_stage [D];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < D; k++) arr_stage[k] <= '0;
        end else if (arr_enable) begin
            for (int k = D - 1; k > 0; k--) arr_stage[k] <= arr_stage[k-1];
            arr_stage[0] <= arr_in;
        end
    end
    assign arr_out = arr_stage[D-1];

    // Reference model: one slot per stage, holding a word or a bubble
    logic         mv [D];
    logic [W-1:0] md [D];
    logic         mflush;
    logic [W-1:0] emitted [$];

    logic         obs_ov, obs_en, obs_ir, obs_fl;
    logic [W-1:0] obs_od;
    logic [2:0]   obs_occ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < D; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
        mflush = 1'b0;
        emitted.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b1; in_data = 8'h5A; flush = 1'b1; out_ready = 1'b1;
        #2;
        chk("rst_in_ready",   in_ready,   0);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_arr_enable", arr_enable, 0);
        chk("rst_flushing",   flushing,   0);
        chk("rst_occupancy",  occupancy,  0);
        chk("rst_arr_in",     arr_in,     0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_data = '0;
        model_clear();
    endtask

    task automatic step(input logic iv, input logic [W-1:0] id, input logic fl, input logic ordy);
        int   occ;
        logic tailv, req, en, ov, ir;
        @(negedge clk);
        in_valid = iv; in_data = id; flush = fl; out_ready = ordy;
        #2;
        occ = 0;
        for (int k = 0; k < D; k++) if (mv[k]) occ++;
        tailv = mv[D-1];
        req   = mflush ? (occ != 0) : iv;
        en    = req && (!tailv || ordy);
        ov    = tailv && req;
        ir    = !mflush && (!tailv || ordy);
        chk("in_ready",   in_ready,   ir);
        chk("out_valid",  out_valid,  ov);
        chk("arr_enable", arr_enable, en);
        chk("occupancy",  occupancy,  occ);
        chk("flushing",   flushing,   mflush);
        if (ov) chk("out_data", out_data, md[D-1]);
        if (en) chk("arr_in", arr_in, mflush ? 32'd0 : 32'(id));
        obs_ov = out_valid; obs_en = arr_enable; obs_ir = in_ready; obs_fl = flushing;
        obs_od = out_data;  obs_occ = occupancy;
        if (out_valid && arr_enable) emitted.push_back(out_data);
        @(posedge clk);
        if (en) begin
            for (int k = D - 1; k > 0; k--) begin
                mv[k] = mv[k-1];
                md[k] = md[k-1];
            end
            mv[0] = !mflush;
            md[0] = mflush ? 8'h00 : id;
        end
        if (!mflush && fl && occ != 0) mflush = 1'b1;
        else if (mflush && occ == 0)   mflush = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        model_clear();
        do_reset();

        // Streaming at full rate
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b1);
            if (i == 5) begin
                chk("t1_first_valid", obs_ov, 1);
                chk("t1_first_data",  obs_od, 8'h01);
            end
        end
        chk("t1_occ_sat", obs_occ, 4);
        chk("t1_count", emitted.size(), 6);
        for (int j = 0; j < emitted.size(); j++) chk("t1_order", emitted[j], j + 1);

        // Partial load then idle input: tail words wait
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            chk("t2_no_valid", obs_ov, 0);
            chk("t2_no_shift", obs_en, 0);
            chk("t2_occ_hold", obs_occ, 3);
        end

        // Full array under backpressure
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'hB1 + 8'(i), 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 8'hB5, 1'b0, 1'b0);
            chk("t3_bp_ready", obs_ir, 0);
            chk("t3_bp_shift", obs_en, 0);
            chk("t3_bp_valid", obs_ov, 1);
            chk("t3_bp_data",  obs_od, 8'hB1);
        end
        step(1'b1, 8'hB5, 1'b0, 1'b1);
        chk("t3_rel_valid", obs_ov, 1);
        chk("t3_rel_data",  obs_od, 8'hB1);
        chk("t3_rel_ready", obs_ir, 1);
        chk("t3_rel_shift", obs_en, 1);

        // Flush drains two words and returns to RUN
        do_reset();
        step(1'b1, 8'hC1, 1'b0, 1'b1);
        step(1'b1, 8'hC2, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int n = 0; n < 12; n++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            if (n == 0) begin
                chk("t4_flushing", obs_fl, 1);
                chk("t4_no_ready", obs_ir, 0);
            end
            if (!obs_fl) break;
        end
        chk("t4_back_run", obs_fl, 0);
        chk("t4_occ_zero", obs_occ, 0);
        chk("t4_count", emitted.size(), 2);
        if (emitted.size() >= 2) begin
            chk("t4_word0", emitted[0], 8'hC1);
            chk("t4_word1", emitted[1], 8'hC2);
        end

        // Flush with stalling sink and a redundant flush pulse
        do_reset();
        step(1'b1, 8'hE1, 1'b0, 1'b1);
        step(1'b1, 8'hE2, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int n = 0; n < 30; n++) begin
            step(1'b0, 8'h00, (n == 2), (n % 3 != 1));
            if (!obs_fl) break;
        end
        chk("t5_back_run", obs_fl, 0);
        chk("t5_count", emitted.size(), 2);
        if (emitted.size() >= 2) begin
            chk("t5_word0", emitted[0], 8'hE1);
            chk("t5_word1", emitted[1], 8'hE2);
        end

        // Reset mid-stream discards in-flight words
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'hF1 + 8'(i), 1'b0, 1'b1);
        #2;
        chk("t6_occ3", occupancy, 3);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'hD1 + 8'(i), 1'b0, 1'b1);
        chk("t6_count", emitted.size(), 4);
        if (emitted.size() >= 1) chk("t6_first", emitted[0], 8'hD1);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
